filter_app_controller: RTL and testbench
========================================

# filter_app_controller

Top-level screen sequencer for the filter application. Owns the user flow preview → filter selection → filter processing → result display, gates the left/right navigation buttons into the select-filter screen, and latches the chosen filter ID. It starts the filter pipeline with a frame-aligned one-cycle pulse and supervises its completion with a frame-counted timeout. It sits between the debounced button inputs and the screen/pixel muxes and filter datapath in the top level.

## Interface
- TIMEOUT_FRAMES, default 120: frames allowed in PROCESS after start before abort.
- NUM_FILTERS, default 6: valid filter IDs are 0..NUM_FILTERS-1.

- clk_in  input  1  pixel clock; all logic on its rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- center_in  input  1  debounced confirm button, level.
- back_in  input  1  debounced back button, level.
- left_in / right_in  input  1 each  debounced navigation buttons, level.
- filter_sel_in  input  3  current selection from the select-filter screen.
- frame_start_in  input  1  one-cycle pulse at start of each frame (hcount=0, vcount=0).
- filter_done_in  input  1  one-cycle pulse from the filter datapath when a frame is finished.
- screen_out  output  2  0=PREVIEW, 1=SELECT, 2=PROCESS, 3=RESULT; drives the top-level pixel mux.
- nav_left_out / nav_right_out  output  1 each  left_in/right_in, registered, forced 0 outside SELECT.
- filter_start_out  output  1  one-cycle start pulse to the filter datapath.
- filter_id_out  output  3  latched filter ID, stable from start until the next confirm.
- busy_out  output  1  high in PROCESS.
- timeout_err_out  output  1  sticky; set on timeout, cleared on the next confirm.

## Operation
- Button edges: rising edge = level & ~previous registered level, for center and back only. Left and right stay level and are gated.
- FSM states: PREVIEW, SELECT, PROCESS, RESULT.
  - PREVIEW: center edge → SELECT.
  - SELECT: back edge → PREVIEW. Center edge with filter_sel_in < NUM_FILTERS → latch filter_id_out, clear timeout_err_out, → PROCESS. Center edge with an invalid ID is ignored.
  - PROCESS: the start pulse is armed on entry. It fires on the first frame_start_in after entry. After the pulse, frame_cnt increments on each frame_start_in.
    - filter_done_in after the pulse → RESULT.
    - frame_cnt reaching TIMEOUT_FRAMES → set timeout_err_out, → PREVIEW.
    - back edge → PREVIEW (abort, no error).
  - RESULT: back edge → SELECT. Center edge → PROCESS (re-run the same ID, re-arm start).
- Simultaneous events:
  - back and center edges in the same cycle: back wins.
  - filter_done_in and timeout in the same cycle: done wins.
  - filter_done_in before the start pulse: ignored.
- frame_cnt is sized to hold TIMEOUT_FRAMES and never wraps. It clears on entry to PROCESS.

## Timing
- Reset values:
  - state PREVIEW; screen_out 0.
  - nav outputs 0; filter_start_out 0.
  - filter_id_out 0; busy_out 0; timeout_err_out 0.
- Edge at cycle t → state change at t+1.
- screen_out follows state but updates only on a frame_start_in cycle, giving tear-free switches. It can lag state by up to one frame.
- busy_out follows state directly with 1-cycle latency.
- filter_start_out goes high exactly in the cycle after the first qualifying frame_start_in, for exactly one cycle.
- nav outputs have 1-cycle latency from inputs. They drop to 0 in the cycle state leaves SELECT.
- Reset asserted mid-PROCESS: all outputs return to reset values immediately (asynchronous). No start pulse is issued after release until a new confirm.

## Structure
- Package filter_app_pkg holds:
  - the state enum (PREVIEW/SELECT/PROCESS/RESULT);
  - screen encodings (SCREEN_PREVIEW..SCREEN_RESULT);
  - filter ID constants shared with the select-filter screen and the filter datapath.
- Sub-module rising_edge_detect (1-bit, clk_in/rst_n_in), instantiated for center and back.
- Everything else, including the FSM, frame counter, start arm flag and pending-screen register, lives in this module.

## Test plan
- Reset, then center edge, then a frame_start_in → state SELECT at the next cycle; screen_out changes 0→1 only at the frame_start_in.
- In SELECT, filter_sel_in=4, center edge → filter_id_out=4 and state PROCESS. Next frame_start_in → a single-cycle filter_start_out. filter_done_in 3 frames later → RESULT, busy_out falls.
- filter_sel_in=6 with center edge → stays in SELECT, no start pulse. Left/right held in PREVIEW → nav outputs stay 0.
- TIMEOUT_FRAMES=4, no filter_done_in → timeout_err_out=1 after the 4th frame_start_in following the start, state PREVIEW. A later confirm clears it.
- Center and back edges in the same cycle in SELECT → PREVIEW. filter_done_in in the same cycle as the timeout → RESULT with no error.
- rst_n_in low mid-PROCESS between armed and fired → outputs reset immediately; no filter_start_out after release.

Source files
------------

// File: rtl/filter_app_pkg.sv
// Shared types and constants for the filter application: screen sequencer
// states, screen mux encodings and the filter ID map used by the
// select-filter screen and the filter datapath.
package filter_app_pkg;

  typedef enum logic [1:0] {
    ST_PREVIEW = 2'd0,
    ST_SELECT  = 2'd1,
    ST_PROCESS = 2'd2,
    ST_RESULT  = 2'd3
  } app_state_t;

  localparam logic [1:0] SCREEN_PREVIEW = 2'd0;
  localparam logic [1:0] SCREEN_SELECT  = 2'd1;
  localparam logic [1:0] SCREEN_PROCESS = 2'd2;
  localparam logic [1:0] SCREEN_RESULT  = 2'd3;

  localparam int unsigned FILTER_ID_W  = 3;
  localparam int unsigned FILTER_COUNT = 6;

  localparam logic [FILTER_ID_W-1:0] FILTER_ID_GRAY    = 3'd0;
  localparam logic [FILTER_ID_W-1:0] FILTER_ID_BLUR    = 3'd1;
  localparam logic [FILTER_ID_W-1:0] FILTER_ID_SHARPEN = 3'd2;
  localparam logic [FILTER_ID_W-1:0] FILTER_ID_EDGE    = 3'd3;
  localparam logic [FILTER_ID_W-1:0] FILTER_ID_INVERT  = 3'd4;
  localparam logic [FILTER_ID_W-1:0] FILTER_ID_SEPIA   = 3'd5;

  // Screen shown on the pixel mux for a given sequencer state.
  function automatic logic [1:0] screen_of(app_state_t s);
    logic [1:0] scr;
    case (s)
      ST_SELECT:  scr = SCREEN_SELECT;
      ST_PROCESS: scr = SCREEN_PROCESS;
      ST_RESULT:  scr = SCREEN_RESULT;
      default:    scr = SCREEN_PREVIEW;
    endcase
    return scr;
  endfunction

endpackage

// File: rtl/filter_app_controller_edge.sv
// Rising-edge detector for a debounced button level. The pulse is
// combinational from the live level, so the consumer acts on the same cycle.
module rising_edge_detect (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;

  // Remember last cycle's level.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) level_q <= 1'b0;
    else           level_q <= level_in;
  end

  assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/filter_app_controller.sv
// Screen sequencer for the filter application: preview -> select -> process
// -> result, with gated navigation, filter ID latch, frame-aligned start
// pulse and frame-counted processing timeout.
module filter_app_controller
  import filter_app_pkg::*;
#(
  parameter int unsigned TIMEOUT_FRAMES = 120,
  parameter int unsigned NUM_FILTERS    = FILTER_COUNT
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       center_in,
  input  logic       back_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic [2:0] filter_sel_in,
  input  logic       frame_start_in,
  input  logic       filter_done_in,
  output logic [1:0] screen_out,
  output logic       nav_left_out,
  output logic       nav_right_out,
  output logic       filter_start_out,
  output logic [2:0] filter_id_out,
  output logic       busy_out,
  output logic       timeout_err_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_FRAMES);

  app_state_t       state, next_state;
  logic             center_rise, back_rise;
  logic             armed, started;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       pending_screen;
  logic             sel_valid, done_ok, timeout_hit, enter_process;

  rising_edge_detect u_center_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .level_in (center_in),
    .rise_out (center_rise)
  );

  rising_edge_detect u_back_edge (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .level_in (back_in),
    .rise_out (back_rise)
  );

  // Next-state decode; back takes priority over center, done over timeout.
  always_comb begin
    next_state  = state;
    sel_valid   = 32'(filter_sel_in) < NUM_FILTERS;
    done_ok     = started & filter_done_in;
    timeout_hit = started & frame_start_in & (frame_cnt == CNT_LAST);
    case (state)
      ST_PREVIEW: if (center_rise && !back_rise) next_state = ST_SELECT;
      ST_SELECT: begin
        if (back_rise)                     next_state = ST_PREVIEW;
        else if (center_rise && sel_valid) next_state = ST_PROCESS;
      end
      ST_PROCESS: begin
        if (back_rise)        next_state = ST_PREVIEW;
        else if (done_ok)     next_state = ST_RESULT;
        else if (timeout_hit) next_state = ST_PREVIEW;
      end
      ST_RESULT: begin
        if (back_rise)        next_state = ST_SELECT;
        else if (center_rise) next_state = ST_PROCESS;
      end
      default:                next_state = ST_PREVIEW;
    endcase
    enter_process = (state != ST_PROCESS) && (next_state == ST_PROCESS);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_PREVIEW;
    else           state <= next_state;
  end

  // Start arming and frame counting; the pulse is suppressed if PROCESS is
  // being left in the very cycle the arming frame arrives.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed            <= 1'b0;
      started          <= 1'b0;
      frame_cnt        <= '0;
      filter_start_out <= 1'b0;
    end else begin
      filter_start_out <= 1'b0;
      if (enter_process) begin
        armed     <= 1'b1;
        started   <= 1'b0;
        frame_cnt <= '0;
      end else if (state == ST_PROCESS && next_state == ST_PROCESS) begin
        if (armed && frame_start_in) begin
          armed            <= 1'b0;
          started          <= 1'b1;
          filter_start_out <= 1'b1;
        end else if (started && frame_start_in && frame_cnt != CNT_MAX) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        armed   <= 1'b0;
        started <= 1'b0;
      end
    end
  end

  // Filter ID latch and sticky timeout flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      filter_id_out   <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      if (state == ST_SELECT && next_state == ST_PROCESS)
        filter_id_out <= filter_sel_in;
      if (enter_process)
        timeout_err_out <= 1'b0;
      else if (state == ST_PROCESS && next_state == ST_PREVIEW && timeout_hit && !back_rise)
        timeout_err_out <= 1'b1;
    end
  end

  // Status and gated navigation outputs, aligned with the state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_out      <= 1'b0;
      nav_left_out  <= 1'b0;
      nav_right_out <= 1'b0;
    end else begin
      busy_out      <= (next_state == ST_PROCESS);
      nav_left_out  <= left_in  & (next_state == ST_SELECT);
      nav_right_out <= right_in & (next_state == ST_SELECT);
    end
  end

  // Screen mux select switches only on frame boundaries to avoid tearing.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_screen <= SCREEN_PREVIEW;
      screen_out     <= SCREEN_PREVIEW;
    end else begin
      pending_screen <= screen_of(next_state);
      if (frame_start_in) screen_out <= pending_screen;
    end
  end

endmodule

// File: tb/tb_filter_app_controller.sv
module tb_filter_app_controller;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       center_in, back_in, left_in, right_in;
  logic [2:0] filter_sel_in;
  logic       frame_start_in, filter_done_in;
  logic [1:0] screen_out;
  logic       nav_left_out, nav_right_out, filter_start_out;
  logic [2:0] filter_id_out;
  logic       busy_out, timeout_err_out;

  int total = 0;
  int bad   = 0;

  filter_app_controller #(.TIMEOUT_FRAMES(4), .NUM_FILTERS(6)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .center_in        (center_in),
    .back_in          (back_in),
    .left_in          (left_in),
    .right_in         (right_in),
    .filter_sel_in    (filter_sel_in),
    .frame_start_in   (frame_start_in),
    .filter_done_in   (filter_done_in),
    .screen_out       (screen_out),
    .nav_left_out     (nav_left_out),
    .nav_right_out    (nav_right_out),
    .filter_start_out (filter_start_out),
    .filter_id_out    (filter_id_out),
    .busy_out         (busy_out),
    .timeout_err_out  (timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic press_center();
    center_in = 1'b1; tick();
    center_in = 1'b0; tick();
  endtask

  task automatic press_back();
    back_in = 1'b1; tick();
    back_in = 1'b0; tick();
  endtask

  task automatic frame();
    frame_start_in = 1'b1; tick();
    frame_start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; center_in = 0; back_in = 0; left_in = 0; right_in = 0;
    filter_sel_in = 0; frame_start_in = 0; filter_done_in = 0;
    tick(); tick();
    total++;
    if ({screen_out, nav_left_out, nav_right_out, filter_start_out, filter_id_out, busy_out, timeout_err_out} !== 10'd0) begin
      bad++; $display("FAIL reset_outputs: got scr=%0d nl=%0b nr=%0b st=%0b id=%0d busy=%0b err=%0b want all 0",
        screen_out, nav_left_out, nav_right_out, filter_start_out, filter_id_out, busy_out, timeout_err_out);
    end
    rst_n_in = 1'b1; tick();
    left_in = 1'b1; right_in = 1'b1; tick(); tick();
    total++;
    if ({nav_left_out, nav_right_out} !== 2'b00) begin
      bad++; $display("FAIL nav_gated_preview: got %b want 00", {nav_left_out, nav_right_out});
    end
    left_in = 1'b0; right_in = 1'b0;
  endtask

  task automatic test_preview_to_select();
    press_center(); tick();
    total++;
    if (screen_out !== 2'd0) begin
      bad++; $display("FAIL screen_waits_frame: got %0d want 0", screen_out);
    end
    frame();
    total++;
    if (screen_out !== 2'd1) begin
      bad++; $display("FAIL screen_select: got %0d want 1", screen_out);
    end
    left_in = 1'b1; tick();
    total++;
    if (nav_left_out !== 1'b1) begin
      bad++; $display("FAIL nav_left_select: got %0b want 1", nav_left_out);
    end
    left_in = 1'b0;
  endtask

  task automatic test_invalid_id();
    filter_sel_in = 3'd6; press_center(); tick();
    total++;
    if (busy_out !== 1'b0) begin
      bad++; $display("FAIL invalid_id_busy: got %0b want 0", busy_out);
    end
    frame();
    total++;
    if (filter_start_out !== 1'b0 || screen_out !== 2'd1) begin
      bad++; $display("FAIL invalid_id_stay: got st=%0b scr=%0d want st=0 scr=1", filter_start_out, screen_out);
    end
  endtask

  task automatic test_process_done();
    right_in = 1'b1; tick();
    filter_sel_in = 3'd4; center_in = 1'b1; tick();
    total++;
    if (busy_out !== 1'b1 || filter_id_out !== 3'd4 || nav_right_out !== 1'b0) begin
      bad++; $display("FAIL confirm_valid: got busy=%0b id=%0d nr=%0b want busy=1 id=4 nr=0", busy_out, filter_id_out, nav_right_out);
    end
    center_in = 1'b0; right_in = 1'b0;
    filter_done_in = 1'b1; tick(); filter_done_in = 1'b0; tick();
    total++;
    if (busy_out !== 1'b1 || filter_start_out !== 1'b0) begin
      bad++; $display("FAIL early_done_ignored: got busy=%0b st=%0b want busy=1 st=0", busy_out, filter_start_out);
    end
    frame();
    total++;
    if (filter_start_out !== 1'b1 || screen_out !== 2'd2) begin
      bad++; $display("FAIL start_pulse: got st=%0b scr=%0d want st=1 scr=2", filter_start_out, screen_out);
    end
    tick();
    total++;
    if (filter_start_out !== 1'b0) begin
      bad++; $display("FAIL start_one_cycle: got %0b want 0", filter_start_out);
    end
    for (int i = 0; i < 3; i++) begin frame(); tick(); end
    filter_done_in = 1'b1; tick(); filter_done_in = 1'b0;
    total++;
    if (busy_out !== 1'b0 || timeout_err_out !== 1'b0) begin
      bad++; $display("FAIL done_result: got busy=%0b err=%0b want busy=0 err=0", busy_out, timeout_err_out);
    end
    frame();
    total++;
    if (screen_out !== 2'd3) begin
      bad++; $display("FAIL screen_result: got %0d want 3", screen_out);
    end
  endtask

  task automatic test_rerun_timeout();
    press_center();
    total++;
    if (busy_out !== 1'b1 || filter_id_out !== 3'd4) begin
      bad++; $display("FAIL rerun_busy: got busy=%0b id=%0d want busy=1 id=4", busy_out, filter_id_out);
    end
    frame();
    total++;
    if (filter_start_out !== 1'b1) begin
      bad++; $display("FAIL rerun_start: got %0b want 1", filter_start_out);
    end
    for (int i = 0; i < 3; i++) begin frame(); tick(); end
    total++;
    if (busy_out !== 1'b1 || timeout_err_out !== 1'b0) begin
      bad++; $display("FAIL before_timeout: got busy=%0b err=%0b want busy=1 err=0", busy_out, timeout_err_out);
    end
    frame();
    total++;
    if (busy_out !== 1'b0 || timeout_err_out !== 1'b1) begin
      bad++; $display("FAIL timeout: got busy=%0b err=%0b want busy=0 err=1", busy_out, timeout_err_out);
    end
    tick(); frame();
    total++;
    if (screen_out !== 2'd0) begin
      bad++; $display("FAIL timeout_preview: got %0d want 0", screen_out);
    end
    press_center(); filter_sel_in = 3'd2; press_center();
    total++;
    if (timeout_err_out !== 1'b0 || filter_id_out !== 3'd2 || busy_out !== 1'b1) begin
      bad++; $display("FAIL confirm_clears_err: got err=%0b id=%0d busy=%0b want err=0 id=2 busy=1", timeout_err_out, filter_id_out, busy_out);
    end
  endtask

  task automatic test_done_vs_timeout();
    frame(); tick();
    for (int i = 0; i < 3; i++) begin frame(); tick(); end
    frame_start_in = 1'b1; filter_done_in = 1'b1; tick();
    frame_start_in = 1'b0; filter_done_in = 1'b0;
    total++;
    if (busy_out !== 1'b0 || timeout_err_out !== 1'b0) begin
      bad++; $display("FAIL done_beats_timeout: got busy=%0b err=%0b want busy=0 err=0", busy_out, timeout_err_out);
    end
    tick(); frame();
    total++;
    if (screen_out !== 2'd3) begin
      bad++; $display("FAIL done_beats_timeout_scr: got %0d want 3", screen_out);
    end
    press_back(); frame();
    total++;
    if (screen_out !== 2'd1 || busy_out !== 1'b0) begin
      bad++; $display("FAIL result_back_select: got scr=%0d busy=%0b want scr=1 busy=0", screen_out, busy_out);
    end
  endtask

  task automatic test_back_vs_center();
    filter_sel_in = 3'd1;
    center_in = 1'b1; back_in = 1'b1; tick();
    center_in = 1'b0; back_in = 1'b0; tick();
    frame();
    total++;
    if (screen_out !== 2'd0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL back_wins: got scr=%0d busy=%0b want scr=0 busy=0", screen_out, busy_out);
    end
  endtask

  task automatic test_reset_mid_process();
    press_center(); frame(); filter_sel_in = 3'd3; press_center();
    total++;
    if (busy_out !== 1'b1 || screen_out !== 2'd1) begin
      bad++; $display("FAIL armed_setup: got busy=%0b scr=%0d want busy=1 scr=1", busy_out, screen_out);
    end
    #2 rst_n_in = 1'b0; #1;
    total++;
    if ({screen_out, filter_start_out, filter_id_out, busy_out, timeout_err_out} !== 8'd0) begin
      bad++; $display("FAIL async_reset: got scr=%0d st=%0b id=%0d busy=%0b err=%0b want all 0",
        screen_out, filter_start_out, filter_id_out, busy_out, timeout_err_out);
    end
    tick(); rst_n_in = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      frame();
      total++;
      if (filter_start_out !== 1'b0 || busy_out !== 1'b0) begin
        bad++; $display("FAIL no_start_after_reset: got st=%0b busy=%0b want 0 0", filter_start_out, busy_out);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_preview_to_select();
    test_invalid_id();
    test_process_done();
    test_rerun_timeout();
    test_done_vs_timeout();
    test_back_vs_center();
    test_reset_mid_process();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
